// File: rtl/keyboard_capture.sv
// keyboard_capture: snoops CPU accesses to PIA1 and keeps a cached copy of the
// physical PET keyboard matrix for the Pi. Port A writes select the scanned row.
// Port B reads return the column byte for that row. A row whose byte changes is
// written into the cache and queued as a {row, byte} event in a small
// first-word-fall-through FIFO.
// Optional build macro: KBD_CAPTURE_DEBOUNCE_EN. When it is defined, a change
// is committed only after two consecutive identical differing scans.
module keyboard_capture #(
  parameter int NUM_ROWS   = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic [1:0]  bus_addr,
  input  logic [7:0]  bus_data_in,
  input  logic        cpu_write,
  input  logic        io_read,
  input  logic        pia1_enabled_in,
  input  logic        kbd_intercept_in,
  input  logic [3:0]  pi_row_addr,
  output logic [7:0]  pi_row_data,
  output logic        evt_valid,
  output logic [11:0] evt_data,
  input  logic        evt_pop,
  output logic        overflow,
  input  logic        overflow_clr
);

  typedef enum logic [1:0] {
    REG_PORTA = 2'd0,
    REG_CRA   = 2'd1,
    REG_PORTB = 2'd2,
    REG_CRB   = 2'd3
  } reg_sel_e;

  localparam int          RIDX_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int          AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [4:0]  ROW_LIMIT = 5'(NUM_ROWS);
  localparam logic [AW:0] PTR_ONE   = (AW + 1)'(1);

  reg_sel_e          reg_sel;
  logic              wr_a;
  logic              rd_b;
  logic              wr_a_q;
  logic              rd_b_q;
  logic [7:0]        data_q;
  logic              icpt_q;
  logic              commit_a;
  logic              commit_b;

  logic [3:0]        row_sel;
  logic [RIDX_W-1:0] ridx;
  logic              row_ok;
  logic [7:0]        cur_row;
  logic              b_take;
  logic              differs;
  logic              do_commit;

  logic [7:0]        matrix [NUM_ROWS];

  logic [11:0]       mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              empty;
  logic              full;
  logic              push;
  logic              push_ok;
  logic              pop_ok;

  logic              pi_ok;

  assign reg_sel = reg_sel_e'(bus_addr);
  assign wr_a    = cpu_write && pia1_enabled_in && (reg_sel == REG_PORTA);
  assign rd_b    = io_read   && pia1_enabled_in && (reg_sel == REG_PORTB);

  // Register the qualified strobes and latch bus data on every high cycle,
  // so the value held at the falling edge is the one from the last high cycle.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_a_q <= 1'b0;
      rd_b_q <= 1'b0;
      data_q <= '0;
      icpt_q <= 1'b0;
    end else begin
      wr_a_q <= wr_a;
      rd_b_q <= rd_b;
      if (wr_a || rd_b) begin
        data_q <= bus_data_in;
        icpt_q <= kbd_intercept_in;
      end
    end
  end

  assign commit_a = wr_a_q && !wr_a;
  assign commit_b = rd_b_q && !rd_b;

  // Row select follows the low nibble of port A writes.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      row_sel <= '0;
    end else if (commit_a) begin
      row_sel <= data_q[3:0];
    end
  end

  assign ridx = row_sel[RIDX_W-1:0];

  // Decide whether a port B read represents a genuine physical change.
  always_comb begin
    row_ok  = ({1'b0, row_sel} < ROW_LIMIT);
    cur_row = row_ok ? matrix[ridx] : 8'hFF;
    b_take  = commit_b && row_ok && !icpt_q;
    differs = (data_q != cur_row);
  end

`ifdef KBD_CAPTURE_DEBOUNCE_EN
  logic [7:0]          pend [NUM_ROWS];
  logic [NUM_ROWS-1:0] pend_v;

  // A change commits only when it matches the byte seen on the previous scan.
  always_comb begin
    do_commit = b_take && differs && pend_v[ridx] && (pend[ridx] == data_q);
  end

  // Track the candidate byte for each row between scans.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
        pend[i] <= 8'hFF;
      end
      pend_v <= '0;
    end else if (b_take) begin
      if (!differs) begin
        pend_v[ridx] <= 1'b0;
      end else if (pend_v[ridx] && (pend[ridx] == data_q)) begin
        pend_v[ridx] <= 1'b0;
      end else begin
        pend[ridx]   <= data_q;
        pend_v[ridx] <= 1'b1;
      end
    end
  end
`else
  // Any differing scan commits immediately.
  always_comb begin
    do_commit = b_take && differs;
  end
`endif

  // Cached keyboard matrix; idle rows read as all keys released.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int unsigned i = 0; i < NUM_ROWS; i++) begin
        matrix[i] <= 8'hFF;
      end
    end else if (do_commit) begin
      matrix[ridx] <= data_q;
    end
  end

  // FIFO status and push/pop qualification. A full FIFO still accepts a push
  // when the head is popped in the same cycle; pop on empty is ignored, so a
  // simultaneous push into an empty FIFO just stores.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push    = do_commit;
    pop_ok  = evt_pop && !empty;
    push_ok = push && (!full || pop_ok);
  end

  // Event FIFO storage and pointers.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= {row_sel, data_q};
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  // Head entry is presented directly; zero when nothing is queued.
  always_comb begin
    evt_valid = !empty;
    evt_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  end

  // Sticky drop flag; a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      overflow <= 1'b0;
    end else if (push && full && !pop_ok) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

  assign pi_ok = ({1'b0, pi_row_addr} < ROW_LIMIT);

  // Pi random-access read port; shows the matrix as it stood before this edge.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pi_row_data <= 8'hFF;
    end else begin
      pi_row_data <= pi_ok ? matrix[pi_row_addr[RIDX_W-1:0]] : 8'hFF;
    end
  end

endmodule

// File: tb/tb_keyboard_capture.sv
// Directed bench for keyboard_capture: table of bus scans with expected events
// and cached row values, plus hand sequences for FIFO overflow, simultaneous
// push/pop while full, pop on empty and reset during an access.
module tb_keyboard_capture;

  logic        clk;
  logic        reset_b;
  logic [1:0]  bus_addr;
  logic [7:0]  bus_data_in;
  logic        cpu_write;
  logic        io_read;
  logic        pia1_enabled_in;
  logic        kbd_intercept_in;
  logic [3:0]  pi_row_addr;
  logic [7:0]  pi_row_data;
  logic        evt_valid;
  logic [11:0] evt_data;
  logic        evt_pop;
  logic        overflow;
  logic        overflow_clr;

  int n_checks = 0;
  int n_fail   = 0;

  keyboard_capture #(.NUM_ROWS(10), .FIFO_DEPTH(8)) dut (
    .clk              (clk),
    .reset_b          (reset_b),
    .bus_addr         (bus_addr),
    .bus_data_in      (bus_data_in),
    .cpu_write        (cpu_write),
    .io_read          (io_read),
    .pia1_enabled_in  (pia1_enabled_in),
    .kbd_intercept_in (kbd_intercept_in),
    .pi_row_addr      (pi_row_addr),
    .pi_row_data      (pi_row_data),
    .evt_valid        (evt_valid),
    .evt_data         (evt_data),
    .evt_pop          (evt_pop),
    .overflow         (overflow),
    .overflow_clr     (overflow_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_pb;
    logic [7:0]  d;
    bit          icpt;
    bit          exp_valid;
    logic [11:0] exp_evt;
    logic [3:0]  pi_addr;
    logic [7:0]  exp_pi;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One PIA access: strobe high for two cycles, then low. The commit edge is
  // the first edge with the strobe low; an optional pop is aligned to it.
  task automatic bus_op(input bit is_pb, input logic [7:0] d, input bit icpt, input bit pop_at_commit);
    @(posedge clk); #1;
    pia1_enabled_in  = 1'b1;
    bus_addr         = is_pb ? 2'd2 : 2'd0;
    bus_data_in      = d;
    kbd_intercept_in = icpt;
    if (is_pb) io_read = 1'b1;
    else       cpu_write = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    io_read          = 1'b0;
    cpu_write        = 1'b0;
    pia1_enabled_in  = 1'b0;
    bus_data_in      = ~d;
    kbd_intercept_in = ~icpt;
    if (pop_at_commit) evt_pop = 1'b1;
    @(posedge clk); #1;
    evt_pop          = 1'b0;
    kbd_intercept_in = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic pop_evt();
    @(posedge clk); #1;
    evt_pop = 1'b1;
    @(posedge clk); #1;
    evt_pop = 1'b0;
  endtask

  task automatic check_pi(input string name, input logic [3:0] addr, input logic [7:0] exp);
    @(posedge clk); #1;
    pi_row_addr = addr;
    @(posedge clk);
    @(negedge clk);
    check(name, {4'h0, pi_row_data}, {4'h0, exp});
  endtask

  initial begin
    reset_b          = 1'b0;
    bus_addr         = 2'd0;
    bus_data_in      = 8'h00;
    cpu_write        = 1'b0;
    io_read          = 1'b0;
    pia1_enabled_in  = 1'b0;
    kbd_intercept_in = 1'b0;
    pi_row_addr      = 4'd0;
    evt_pop          = 1'b0;
    overflow_clr     = 1'b0;

    //           is_pb  d      icpt valid evt      pi   exp_pi
    vecs[0]  = '{1'b0, 8'h03, 1'b0, 1'b0, 12'h000, 4'd3,  8'hFF};
    vecs[1]  = '{1'b1, 8'hFE, 1'b0, 1'b1, 12'h3FE, 4'd3,  8'hFE};
    vecs[2]  = '{1'b1, 8'hFE, 1'b0, 1'b0, 12'h000, 4'd3,  8'hFE};
    vecs[3]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 12'h3FF, 4'd3,  8'hFF};
    vecs[4]  = '{1'b0, 8'h0C, 1'b0, 1'b0, 12'h000, 4'd12, 8'hFF};
    vecs[5]  = '{1'b1, 8'h00, 1'b0, 1'b0, 12'h000, 4'd12, 8'hFF};
    vecs[6]  = '{1'b0, 8'hF2, 1'b0, 1'b0, 12'h000, 4'd2,  8'hFF};
    vecs[7]  = '{1'b1, 8'h7F, 1'b1, 1'b0, 12'h000, 4'd2,  8'hFF};
    vecs[8]  = '{1'b1, 8'h7F, 1'b0, 1'b1, 12'h27F, 4'd2,  8'h7F};
    vecs[9]  = '{1'b0, 8'h09, 1'b0, 1'b0, 12'h000, 4'd9,  8'hFF};
    vecs[10] = '{1'b1, 8'h55, 1'b0, 1'b1, 12'h955, 4'd9,  8'h55};

    repeat (3) @(posedge clk);
    #1 reset_b = 1'b1;

    // Reset state.
    for (int a = 0; a < 11; a++) begin
      check_pi("reset_pi_row", (a == 10) ? 4'd15 : 4'(a), 8'hFF);
    end
    @(negedge clk);
    check("reset_evt_valid", {11'h0, evt_valid}, 12'h000);
    check("reset_evt_data", evt_data, 12'h000);
    check("reset_overflow", {11'h0, overflow}, 12'h000);

`ifndef KBD_CAPTURE_DEBOUNCE_EN
    // Table-driven scans.
    for (int i = 0; i < 11; i++) begin
      bus_op(vecs[i].is_pb, vecs[i].d, vecs[i].icpt, 1'b0);
      check_pi("vec_pi_row", vecs[i].pi_addr, vecs[i].exp_pi);
      check("vec_evt_valid", {11'h0, evt_valid}, {11'h0, vecs[i].exp_valid});
      if (vecs[i].exp_valid) begin
        check("vec_evt_data", evt_data, vecs[i].exp_evt);
        pop_evt();
        @(negedge clk);
        check("vec_evt_drained", {11'h0, evt_valid}, 12'h000);
      end
    end

    // Nine changes without popping: eight kept, overflow set, matrix updated.
    bus_op(1'b0, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 9; i++) begin
      bus_op(1'b1, 8'(i), 1'b0, 1'b0);
    end
    @(negedge clk);
    check("ovf_set", {11'h0, overflow}, 12'h001);
    check_pi("ovf_matrix_updated", 4'd0, 8'h09);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("ovf_drain_order", evt_data, {4'h0, 8'(i)});
      pop_evt();
    end
    @(negedge clk);
    check("ovf_drained_empty", {11'h0, evt_valid}, 12'h000);
    check("ovf_still_sticky", {11'h0, overflow}, 12'h001);
    @(posedge clk); #1 overflow_clr = 1'b1;
    @(posedge clk); #1 overflow_clr = 1'b0;
    @(negedge clk);
    check("ovf_cleared", {11'h0, overflow}, 12'h000);

    // Full FIFO with push and pop on the same edge: both succeed.
    for (int i = 0; i < 8; i++) begin
      bus_op(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
    end
    bus_op(1'b1, 8'h19, 1'b0, 1'b1);
    @(negedge clk);
    check("fullpp_no_overflow", {11'h0, overflow}, 12'h000);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("fullpp_drain_order", evt_data, {4'h0, 8'h12 + 8'(i)});
      pop_evt();
    end
    @(negedge clk);
    check("fullpp_empty", {11'h0, evt_valid}, 12'h000);

    // Pop on empty is ignored and does not disturb the next event.
    pop_evt();
    @(negedge clk);
    check("pop_empty_valid", {11'h0, evt_valid}, 12'h000);
    bus_op(1'b1, 8'h20, 1'b0, 1'b0);
    @(negedge clk);
    check("pop_empty_next_evt", evt_data, 12'h020);
    pop_evt();

    // Reset during a port A write: the write is discarded, state returns to reset.
    bus_op(1'b0, 8'h09, 1'b0, 1'b0);
    @(posedge clk); #1;
    pia1_enabled_in = 1'b1;
    bus_addr        = 2'd0;
    bus_data_in     = 8'h05;
    cpu_write       = 1'b1;
    @(posedge clk); #1;
    reset_b = 1'b0;
    #2;
    cpu_write       = 1'b0;
    pia1_enabled_in = 1'b0;
    @(posedge clk); #1;
    reset_b = 1'b1;
    check_pi("rst_mid_matrix", 4'd0, 8'hFF);
    check("rst_mid_evt_valid", {11'h0, evt_valid}, 12'h000);
    bus_op(1'b1, 8'hAA, 1'b0, 1'b0);
    @(negedge clk);
    check("rst_mid_row_sel", evt_data, 12'h0AA);
    pop_evt();
`else
    // Debounced capture: a change needs two matching scans.
    bus_op(1'b0, 8'h01, 1'b0, 1'b0);
    bus_op(1'b1, 8'hEF, 1'b0, 1'b0);
    @(negedge clk);
    check("db_first_scan_no_evt", {11'h0, evt_valid}, 12'h000);
    check_pi("db_first_scan_row", 4'd1, 8'hFF);
    bus_op(1'b1, 8'hEF, 1'b0, 1'b0);
    @(negedge clk);
    check("db_second_scan_evt", {11'h0, evt_valid}, 12'h001);
    check("db_second_scan_data", evt_data, 12'h1EF);
    check_pi("db_second_scan_row", 4'd1, 8'hEF);
    pop_evt();
    bus_op(1'b0, 8'h02, 1'b0, 1'b0);
    bus_op(1'b1, 8'hEF, 1'b0, 1'b0);
    bus_op(1'b1, 8'hDF, 1'b0, 1'b0);
    bus_op(1'b1, 8'hFF, 1'b0, 1'b0);
    @(negedge clk);
    check("db_bounce_no_evt", {11'h0, evt_valid}, 12'h000);
    check_pi("db_bounce_row", 4'd2, 8'hFF);
    bus_op(1'b1, 8'hDF, 1'b0, 1'b0);
    @(negedge clk);
    check("db_reload_no_evt", {11'h0, evt_valid}, 12'h000);
    bus_op(1'b1, 8'hDF, 1'b0, 1'b0);
    @(negedge clk);
    check("db_reload_evt", evt_data, 12'h2DF);
    pop_evt();
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
